ddr2_cmd_issue_gate: RTL
========================

// Module: ddr2_cmd_issue_gate
// PURPOSE
//  Timing-safe DDR2 command issue stage. Accepts one command request per cycle from the controller
//  scheduler and holds it until every per-bank and global timer allows it. It then drives the
//  command onto the pad-level control bus for one clk. Sits directly upstream of the pad timing
//  checker, which must never fire on traffic produced by this block.
// PARAMETERS
//  TRCD_MIN  4   ACT->RD/WR, same bank (clk)
//  TRP_MIN   4   PRE->ACT, same bank (clk)
//  TRAS_MIN  8   ACT->PRE, same bank (clk)
//  TRFC_MIN  16  REF->REF and REF->ACT (clk)
//  TRRD_MIN  2   ACT->ACT, any bank (clk)
//  TFAW_MIN  16  window for four ACTs (clk)
// PORTS
//  clk          in   1   controller clock
//  reset        in   1   synchronous, active-high
//  req_valid    in   1   command request present
//  req_cmd      in   3   0 NOP, 1 ACT, 2 PRE, 3 REF, 4 RD, 5 WR; 6-7 illegal
//  req_ba       in   2   target bank
//  req_addr     in   13  row (ACT) / column (RD/WR); A10=1 on PRE means precharge-all
//  req_ready    out  1   request accepted this cycle when req_valid=1
//  err_illegal  out  1   one-cycle pulse: request consumed but not issued
//  cke_pad      out  1   clock enable
//  csbar_pad    out  1   chip select, active low
//  rasbar_pad   out  1   RAS#
//  casbar_pad   out  1   CAS#
//  webar_pad    out  1   WE#
//  ba_pad       out  2   bank address
//  a_pad        out  13  address
// BEHAVIOUR
//  - Reset values (also on reset asserted mid-operation):
//    - cke_pad=0; pad command = NOP (cs#=0, ras#=cas#=we#=1); ba_pad=0, a_pad=0.
//    - req_ready=0, err_illegal=0.
//    - All banks idle; all timers saturated, so the first command is not delayed.
//    - Any pending request is dropped.
//  - cke_pad rises on the first clk after reset deasserts. req_ready=0 while cke_pad=0.
//  - Handshake:
//    - Transfer on req_valid & req_ready.
//    - req_ready is combinational from the current request and the timer state; it does not depend on history of req_valid.
//    - Requester holds cmd/ba/addr stable until the transfer.
//  - Latency: an accepted command appears on the pads on the next clk, for exactly one cycle, then NOP.
//  - Throughput: at most one pad command per cycle.
//  - Timers: 8-bit per-bank since_act/since_pre; 16-bit since_ref and since_act_any; all saturate at all-ones.
//    Each timer loads 0 in the cycle its command is driven on the pads.
//  - Per-bank state: idle or active.
//    - ACT: idle->active.
//    - PRE: ->idle. PRE with A10=1 idles all banks.
//  - Required pad separation in clk edges, d = issue cycle minus reference cycle:
//    - ACT: bank idle; d(PRE same bank) >= TRP_MIN+1; d(last ACT any bank) >= TRRD_MIN+1;
//      d(4th-previous ACT) >= TFAW_MIN (4-entry timestamp FIFO); d(last REF) >= TRFC_MIN+1.
//    - PRE: d(ACT same bank) >= TRAS_MIN+1. For precharge-all this applies to every active bank.
//      PRE to an idle bank is issued immediately.
//    - RD/WR: bank active; d(ACT same bank) >= TRCD_MIN+1.
//    - REF: all banks idle; d(last PRE any bank) >= TRP_MIN+1; d(last REF) >= TRFC_MIN+1.
//  - Consumed-not-issued cases (req_ready=1, err_illegal pulses the next cycle, pads stay NOP):
//    - ACT to an active bank; RD/WR to an idle bank; REF with any bank active; req_cmd 6-7.
//  - NOP request: accepted immediately, no pad activity, no error.
//  - Timers keep running while the gate stalls. A stalled request never starves: it issues in the
//    first cycle all of its conditions hold.
// TESTING (defaults)
//  - ACT b0 at pad cycle t, then RD b0 offered at once -> RD on pads at t+5, not earlier; req_ready low t..t+3.
//  - ACT b1 at t, PRE b1 offered next -> PRE at t+9; ACT b1 re-offered -> ACT at t+14.
//  - ACT b0,b1,b2,b3 back-to-back -> pads at t, t+3, t+6, t+9; 5th ACT b0 after PRE -> not before t+16 (tFAW).
//  - REF twice -> second REF exactly 17 cycles after first; ACT after REF not before +17.
//  - RD to idle bank 2 -> accepted, err_illegal=1 for one cycle, pads stay NOP; the next legal command is unaffected.
//  - reset asserted while an ACT is stalled -> pads NOP, cke_pad=0 next cycle, request dropped, timers saturated after release.

Source files
------------

// File: rtl/ddr2_cmd_issue_gate.sv
// DDR2 command issue gate.
// Holds one scheduler request until every per-bank and global timing
// constraint allows it, then drives it on the pad control bus for one clk.
// Requests that can never be legal in the current bank state are consumed
// without issue and flagged on err_illegal.
module ddr2_cmd_issue_gate #(
    parameter int TRCD_MIN = 4,
    parameter int TRP_MIN  = 4,
    parameter int TRAS_MIN = 8,
    parameter int TRFC_MIN = 16,
    parameter int TRRD_MIN = 2,
    parameter int TFAW_MIN = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_cmd,
    input  logic [1:0]  req_ba,
    input  logic [12:0] req_addr,
    output logic        req_ready,
    output logic        err_illegal,
    output logic        cke_pad,
    output logic        csbar_pad,
    output logic        rasbar_pad,
    output logic        casbar_pad,
    output logic        webar_pad,
    output logic [1:0]  ba_pad,
    output logic [12:0] a_pad
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_PRE = 3'd2;
    localparam logic [2:0] CMD_REF = 3'd3;
    localparam logic [2:0] CMD_RD  = 3'd4;
    localparam logic [2:0] CMD_WR  = 3'd5;

    // A timer holds (issue cycle - reference cycle - 1) when a request is
    // evaluated, because the request reaches the pads one clk later.
    localparam logic [7:0]  TRCD_C = 8'(TRCD_MIN);
    localparam logic [7:0]  TRP_C  = 8'(TRP_MIN);
    localparam logic [7:0]  TRAS_C = 8'(TRAS_MIN);
    localparam logic [15:0] TRFC_C = 16'(TRFC_MIN);
    localparam logic [15:0] TRRD_C = 16'(TRRD_MIN);
    localparam logic [7:0]  TFAW_C = 8'(TFAW_MIN - 1);

    function automatic logic [7:0] sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic            cke_q;
    logic            err_q;
    logic [3:0]      bank_active_q, bank_active_d;
    logic [3:0][7:0] since_act_q, since_act_d;
    logic [3:0][7:0] since_pre_q, since_pre_d;
    logic [15:0]     since_ref_q, since_ref_d;
    logic [15:0]     since_act_any_q, since_act_any_d;
    // Ages of the four most recent ACTs; entry 3 is the oldest.
    logic [3:0][7:0] faw_age_q, faw_age_d;
    logic            cs_q, ras_q, cas_q, we_q;
    logic            cs_d, ras_d, cas_d, we_d;
    logic [1:0]      ba_q, ba_d;
    logic [12:0]     a_q, a_d;

    logic cmd_ok;
    logic cmd_bad;
    logic xfer;
    logic issue;

    // Classify the current request: issuable now (cmd_ok) or never legal (cmd_bad).
    always_comb begin
        cmd_ok  = 1'b0;
        cmd_bad = 1'b0;
        case (req_cmd)
            CMD_NOP: cmd_ok = 1'b1;
            CMD_ACT: begin
                if (bank_active_q[req_ba]) begin
                    cmd_bad = 1'b1;
                end else begin
                    cmd_ok = (since_pre_q[req_ba] >= TRP_C) &&
                             (since_act_any_q >= TRRD_C) &&
                             (faw_age_q[3] >= TFAW_C) &&
                             (since_ref_q >= TRFC_C);
                end
            end
            CMD_PRE: begin
                cmd_ok = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if ((req_addr[10] || (req_ba == 2'(b))) && bank_active_q[2'(b)] &&
                        (since_act_q[2'(b)] < TRAS_C)) begin
                        cmd_ok = 1'b0;
                    end else begin
                        cmd_ok = cmd_ok;
                    end
                end
            end
            CMD_REF: begin
                if (|bank_active_q) begin
                    cmd_bad = 1'b1;
                end else begin
                    cmd_ok = (since_ref_q >= TRFC_C);
                    for (int b = 0; b < 4; b++) begin
                        if (since_pre_q[2'(b)] < TRP_C) begin
                            cmd_ok = 1'b0;
                        end else begin
                            cmd_ok = cmd_ok;
                        end
                    end
                end
            end
            CMD_RD, CMD_WR: begin
                if (!bank_active_q[req_ba]) begin
                    cmd_bad = 1'b1;
                end else begin
                    cmd_ok = (since_act_q[req_ba] >= TRCD_C);
                end
            end
            default: cmd_bad = 1'b1;
        endcase
    end

    assign req_ready = cke_q && !reset && (cmd_ok || cmd_bad);
    assign xfer      = req_valid && req_ready;
    assign issue     = xfer && cmd_ok && (req_cmd != CMD_NOP);

    // Next bank state and timer values; issued commands restart their timers.
    always_comb begin
        bank_active_d   = bank_active_q;
        since_ref_d     = sat16(since_ref_q);
        since_act_any_d = sat16(since_act_any_q);
        for (int b = 0; b < 4; b++) begin
            since_act_d[2'(b)] = sat8(since_act_q[2'(b)]);
            since_pre_d[2'(b)] = sat8(since_pre_q[2'(b)]);
            faw_age_d[2'(b)]   = sat8(faw_age_q[2'(b)]);
        end
        if (issue && (req_cmd == CMD_ACT)) begin
            bank_active_d[req_ba] = 1'b1;
            since_act_d[req_ba]   = 8'd0;
            since_act_any_d       = 16'd0;
            faw_age_d[0]          = 8'd0;
            for (int i = 1; i < 4; i++) begin
                faw_age_d[2'(i)] = sat8(faw_age_q[2'(i - 1)]);
            end
        end else if (issue && (req_cmd == CMD_PRE)) begin
            for (int b = 0; b < 4; b++) begin
                if (req_addr[10] || (req_ba == 2'(b))) begin
                    bank_active_d[2'(b)] = 1'b0;
                    since_pre_d[2'(b)]   = 8'd0;
                end else begin
                    bank_active_d[2'(b)] = bank_active_q[2'(b)];
                end
            end
        end else if (issue && (req_cmd == CMD_REF)) begin
            since_ref_d = 16'd0;
        end else begin
            bank_active_d = bank_active_q;
        end
    end

    // Pad word for the next cycle: the issued command, otherwise NOP with zeroed address.
    always_comb begin
        cs_d  = 1'b0;
        ras_d = 1'b1;
        cas_d = 1'b1;
        we_d  = 1'b1;
        ba_d  = 2'd0;
        a_d   = 13'd0;
        if (issue) begin
            ba_d = req_ba;
            a_d  = req_addr;
            case (req_cmd)
                CMD_ACT: ras_d = 1'b0;
                CMD_PRE: begin ras_d = 1'b0; we_d = 1'b0; end
                CMD_REF: begin ras_d = 1'b0; cas_d = 1'b0; end
                CMD_RD:  cas_d = 1'b0;
                CMD_WR:  begin cas_d = 1'b0; we_d = 1'b0; end
                default: ras_d = 1'b1;
            endcase
        end else begin
            cs_d = 1'b0;
        end
    end

    // State registers; reset idles banks, saturates timers and parks pads on NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            cke_q           <= 1'b0;
            err_q           <= 1'b0;
            bank_active_q   <= 4'd0;
            since_act_q     <= {4{8'hFF}};
            since_pre_q     <= {4{8'hFF}};
            since_ref_q     <= 16'hFFFF;
            since_act_any_q <= 16'hFFFF;
            faw_age_q       <= {4{8'hFF}};
            cs_q            <= 1'b0;
            ras_q           <= 1'b1;
            cas_q           <= 1'b1;
            we_q            <= 1'b1;
            ba_q            <= 2'd0;
            a_q             <= 13'd0;
        end else begin
            cke_q           <= 1'b1;
            err_q           <= xfer && cmd_bad;
            bank_active_q   <= bank_active_d;
            since_act_q     <= since_act_d;
            since_pre_q     <= since_pre_d;
            since_ref_q     <= since_ref_d;
            since_act_any_q <= since_act_any_d;
            faw_age_q       <= faw_age_d;
            cs_q            <= cs_d;
            ras_q           <= ras_d;
            cas_q           <= cas_d;
            we_q            <= we_d;
            ba_q            <= ba_d;
            a_q             <= a_d;
        end
    end

    assign err_illegal = err_q;
    assign cke_pad     = cke_q;
    assign csbar_pad   = cs_q;
    assign rasbar_pad  = ras_q;
    assign casbar_pad  = cas_q;
    assign webar_pad   = we_q;
    assign ba_pad      = ba_q;
    assign a_pad       = a_q;

endmodule
